decode_stage: RTL

- Second pipeline stage; sits directly downstream of the fetch stage.
- Consumes the registered 16-bit instruction word and 32-bit PC+1 from fetch.
- Decodes the instruction and reads the 8x16 register file. Assembles two-word instructions (opcode word followed by an immediate word).
- Detects load-use hazards and drives fetch's pc_enable and clear_instruction. Produces the registered ID/EX pipeline bundle.

---
 rtl/decode_pkg.sv | 73 +++++++
 rtl/decode_stage_reg_file.sv | 32 +++
 rtl/decode_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode map, FSM states, the ID/EX bundle and
// per-opcode attribute helpers used by the decode stage.
package decode_pkg;

  localparam int DEC_DATA_W    = 16;
  localparam int DEC_PC_W      = 32;
  localparam int DEC_REG_COUNT = 8;
  localparam int DEC_AW        = $clog2(DEC_REG_COUNT);
  localparam int OPC_W         = 5;

  localparam logic [OPC_W-1:0] OP_NOP  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_INC  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_MOV  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_IADD = 5'b01100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b01101;
  localparam logic [OPC_W-1:0] OP_POP  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_LDM  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_LDD  = 5'b10011;
  localparam logic [OPC_W-1:0] OP_STD  = 5'b10100;
  localparam logic [OPC_W-1:0] OP_PUSH = 5'b10101;

  typedef enum logic {S_DECODE = 1'b0, S_IMM = 1'b1} fsm_state_t;

  typedef struct packed {
    logic                  valid;
    logic [OPC_W-1:0]      opcode;
    logic [DEC_AW-1:0]     rdst;
    logic [DEC_AW-1:0]     rsrc1;
    logic [DEC_AW-1:0]     rsrc2;
    logic [DEC_DATA_W-1:0] op1;
    logic [DEC_DATA_W-1:0] op2;
    logic [DEC_DATA_W-1:0] imm;
    logic [DEC_PC_W-1:0]   pc_plus_one;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } idex_t;

  // NOP is deliberately not "known": it decodes to a bubble like any unknown opcode.
  function automatic logic is_known(input logic [OPC_W-1:0] op);
    return op inside {OP_NOT, OP_INC, OP_MOV, OP_ADD, OP_SUB, OP_IADD, OP_AND,
                      OP_POP, OP_LDM, OP_LDD, OP_STD, OP_PUSH};
  endfunction

  function automatic logic is_imm_op(input logic [OPC_W-1:0] op);
    return op inside {OP_LDM, OP_IADD, OP_LDD, OP_STD};
  endfunction

  function automatic logic is_load(input logic [OPC_W-1:0] op);
    return op inside {OP_LDD, OP_POP};
  endfunction

  function automatic logic is_store(input logic [OPC_W-1:0] op);
    return op inside {OP_STD, OP_PUSH};
  endfunction

  function automatic logic writes_reg(input logic [OPC_W-1:0] op);
    return is_known(op) && !is_store(op);
  endfunction

  function automatic logic uses_src1(input logic [OPC_W-1:0] op);
    return op inside {OP_NOT, OP_INC, OP_MOV, OP_ADD, OP_SUB, OP_IADD, OP_AND,
                      OP_LDD, OP_STD, OP_PUSH};
  endfunction

  function automatic logic uses_src2(input logic [OPC_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_STD};
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Register file: REG_COUNT x DATA_W, one write port, two write-first read
// ports, cleared by the asynchronous active-low reset.
module reg_file #(
  parameter int DATA_W    = 16,
  parameter int REG_COUNT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we_i,
  input  logic [$clog2(REG_COUNT)-1:0] waddr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [$clog2(REG_COUNT)-1:0] raddr1_i,
  input  logic [$clog2(REG_COUNT)-1:0] raddr2_i,
  output logic [DATA_W-1:0]            rdata1_o,
  output logic [DATA_W-1:0]            rdata2_o
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Same-cycle write-back is forwarded so decode never sees a stale value.
  assign rdata1_o = (we_i && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (we_i && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register read, two-word instruction assembly, load-use stall
// and flush handling, registered ID/EX bundle. DECODE_STALL_CNT_EN adds stall_count.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W    = DEC_DATA_W,
  parameter int PC_W      = DEC_PC_W,
  parameter int REG_COUNT = DEC_REG_COUNT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [15:0]                  instruction,
  input  logic [PC_W-1:0]              pc_plus_one,
  input  logic                         flush,
  input  logic                         wb_en,
  input  logic [$clog2(REG_COUNT)-1:0] wb_addr,
  input  logic [DATA_W-1:0]            wb_data,
  output logic                         pc_enable_out,
  output logic                         clear_instruction_out,
  output logic                         idex_valid,
  output logic [4:0]                   idex_opcode,
  output logic [$clog2(REG_COUNT)-1:0] idex_rdst,
  output logic [$clog2(REG_COUNT)-1:0] idex_rsrc1,
  output logic [$clog2(REG_COUNT)-1:0] idex_rsrc2,
  output logic [DATA_W-1:0]            idex_op1,
  output logic [DATA_W-1:0]            idex_op2,
  output logic [DATA_W-1:0]            idex_imm,
  output logic [PC_W-1:0]              idex_pc_plus_one,
  output logic                         idex_reg_write,
  output logic                         idex_mem_read,
  output logic                         idex_mem_write
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_count
`endif
);

  localparam int AW = $clog2(REG_COUNT);

  fsm_state_t        state_q, state_d;
  idex_t             idex_q, idex_d, hold_q, hold_d, dec;
  logic [OPC_W-1:0]  opc;
  logic [AW-1:0]     rdst, rsrc1, rsrc2;
  logic [DATA_W-1:0] rd1, rd2;
  logic              hazard, stall;

  assign opc   = instruction[15:11];
  assign rdst  = instruction[10:8];
  assign rsrc1 = instruction[7:5];
  assign rsrc2 = instruction[4:2];

  reg_file #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT)) u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .we_i     (wb_en),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr1_i (rsrc1),
    .raddr2_i (rsrc2),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  // In S_IMM the word is an immediate, so its bit fields must not trigger a stall.
  assign hazard = (state_q == S_DECODE) && idex_q.valid && idex_q.mem_read &&
                  ((uses_src1(opc) && idex_q.rdst == rsrc1) ||
                   (uses_src2(opc) && idex_q.rdst == rsrc2));
  assign stall  = hazard && !flush;

  assign pc_enable_out         = !stall;
  assign clear_instruction_out = flush;

  always_comb begin
    dec = '0;
    if (is_known(opc)) begin
      dec.valid       = 1'b1;
      dec.opcode      = opc;
      dec.rdst        = rdst;
      dec.rsrc1       = rsrc1;
      dec.rsrc2       = rsrc2;
      dec.op1         = rd1;
      dec.op2         = rd2;
      dec.pc_plus_one = pc_plus_one;
      dec.reg_write   = writes_reg(opc);
      dec.mem_read    = is_load(opc);
      dec.mem_write   = is_store(opc);
    end

    state_d = state_q;
    hold_d  = hold_q;
    idex_d  = '0;
    if (flush) begin
      state_d = S_DECODE;
      hold_d  = '0;
    end else if (state_q == S_IMM) begin
      idex_d     = hold_q;
      idex_d.imm = instruction;
      state_d    = S_DECODE;
      hold_d     = '0;
    end else if (!hazard) begin
      if (is_imm_op(opc)) begin
        hold_d  = dec;
        state_d = S_IMM;
      end else begin
        idex_d = dec;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_DECODE;
      hold_q  <= '0;
      idex_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idex_q  <= idex_d;
    end
  end

  assign idex_valid       = idex_q.valid;
  assign idex_opcode      = idex_q.opcode;
  assign idex_rdst        = idex_q.rdst;
  assign idex_rsrc1       = idex_q.rsrc1;
  assign idex_rsrc2       = idex_q.rsrc2;
  assign idex_op1         = idex_q.op1;
  assign idex_op2         = idex_q.op2;
  assign idex_imm         = idex_q.imm;
  assign idex_pc_plus_one = idex_q.pc_plus_one;
  assign idex_reg_write   = idex_q.reg_write;
  assign idex_mem_read    = idex_q.mem_read;
  assign idex_mem_write   = idex_q.mem_write;

`ifdef DECODE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule
